// File: rtl/dmem_dump_pkg.sv
// Shared types and constants for the data-memory dump arbiter.
package dmem_dump_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } dump_state_e;

  localparam int WORD_BYTES = 8;
  localparam int WORD_SHIFT = $clog2(WORD_BYTES);

endpackage

// File: rtl/dump_index_counter.sv
// Word index for the memory dump: cleared on request, advanced per handshake,
// saturating at DEPTH-1 so it never wraps while a dump is in progress.
module dump_index_counter #(
  parameter int DEPTH = 128,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [IW-1:0] index,
  output logic          last
);

  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  assign last = (index == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      index <= '0;
    end else if (clear) begin
      index <= '0;
    end else if (enable && !last) begin
      index <= index + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_dump_arbiter.sv
// Shares the data memory between the CPU MEM stage and a stalling, handshaked
// dump engine that streams DEPTH 64-bit words out to a consumer.
module dmem_dump_arbiter
  import dmem_dump_pkg::*;
#(
  parameter int N     = 64,
  parameter int DEPTH = 128
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         dump,
  input  logic         cpu_memRead,
  input  logic         cpu_memWrite,
  input  logic [N-1:0] cpu_addr,
  input  logic [N-1:0] cpu_writeData,
  output logic [N-1:0] cpu_readData,
  output logic         cpu_stall,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_writeData,
  output logic         mem_writeEnable,
  output logic         mem_readEnable,
  input  logic [N-1:0] mem_readData,
  output logic         dump_valid,
  input  logic         dump_ready,
  output logic [N-1:0] dump_addr,
  output logic [N-1:0] dump_data,
  output logic         dump_done
);

  localparam int IW = $clog2(DEPTH);

  dump_state_e   state, state_next;
  logic [IW-1:0] index;
  logic          index_last;
  logic          in_idle, in_dump, in_done;
  logic          handshake;
  logic [N-1:0]  index_addr;

  assign in_idle   = (state == IDLE);
  assign in_dump   = (state == DUMP);
  assign in_done   = (state == DONE);
  assign handshake = in_dump && dump_ready;

  dump_index_counter #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_index (
    .clk    (CLOCK_50),
    .reset  (reset),
    .clear  (in_idle),
    .enable (handshake),
    .index  (index),
    .last   (index_last)
  );

  assign index_addr = {{(N - IW){1'b0}}, index} << WORD_SHIFT;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (dump) state_next = DUMP;
      DUMP:    if (handshake && index_last) state_next = DONE;
      DONE:    if (!dump) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Control strobes are forced low while reset is held, before the state register settles.
  assign cpu_stall       = !reset && (in_dump || in_done);
  assign dump_valid      = !reset && in_dump;
  assign dump_done       = !reset && in_done;
  assign mem_writeEnable = !reset && in_idle && cpu_memWrite;
  assign mem_readEnable  = !reset && ((in_idle && cpu_memRead) || in_dump);

  assign mem_addr      = in_dump ? index_addr : cpu_addr;
  assign mem_writeData = cpu_writeData;
  assign cpu_readData  = in_idle ? mem_readData : '0;
  assign dump_addr     = reset ? '0 : index_addr;
  assign dump_data     = in_dump ? mem_readData : '0;

endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// Directed bench for dmem_dump_arbiter with a 128-word combinational-read memory model.
module tb_dmem_dump_arbiter;

  localparam int N     = 64;
  localparam int DEPTH = 128;

  logic         CLOCK_50 = 1'b0;
  logic         reset, dump;
  logic         cpu_memRead, cpu_memWrite;
  logic [N-1:0] cpu_addr, cpu_writeData, cpu_readData;
  logic         cpu_stall;
  logic [N-1:0] mem_addr, mem_writeData, mem_readData;
  logic         mem_writeEnable, mem_readEnable;
  logic         dump_valid, dump_ready, dump_done;
  logic [N-1:0] dump_addr, dump_data;

  int checks   = 0;
  int failures = 0;

  logic [63:0] mem     [DEPTH];
  logic [63:0] exp_mem [DEPTH];

  always #5 CLOCK_50 = ~CLOCK_50;

  dmem_dump_arbiter #(.N(N), .DEPTH(DEPTH)) dut (
    .CLOCK_50        (CLOCK_50),
    .reset           (reset),
    .dump            (dump),
    .cpu_memRead     (cpu_memRead),
    .cpu_memWrite    (cpu_memWrite),
    .cpu_addr        (cpu_addr),
    .cpu_writeData   (cpu_writeData),
    .cpu_readData    (cpu_readData),
    .cpu_stall       (cpu_stall),
    .mem_addr        (mem_addr),
    .mem_writeData   (mem_writeData),
    .mem_writeEnable (mem_writeEnable),
    .mem_readEnable  (mem_readEnable),
    .mem_readData    (mem_readData),
    .dump_valid      (dump_valid),
    .dump_ready      (dump_ready),
    .dump_addr       (dump_addr),
    .dump_data       (dump_data),
    .dump_done       (dump_done)
  );

  function automatic logic [63:0] pattern(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  // Memory contents reload on reset so every run starts from a known image.
  assign mem_readData = mem[mem_addr[9:3]];
  always @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pattern(i);
    end else if (mem_writeEnable) begin
      mem[mem_addr[9:3]] <= mem_writeData;
    end
  end

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = pattern(i);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Entered one step after the edge that put the FSM in DUMP.
  task automatic run_dump(input int drop_at, input int bp_at, input int abort_at,
                          output int words);
    int k   = 0;
    int cyc = 0;
    while (dump_valid === 1'b1 && cyc < 400) begin
      chk("dump_addr", dump_addr, 64'(k * 8));
      chk("mem_addr", mem_addr, 64'(k * 8));
      chk("dump_data", dump_data, exp_mem[k]);
      chk("dump_stall", {63'd0, cpu_stall}, 64'd1);
      chk("dump_we", {63'd0, mem_writeEnable}, 64'd0);
      chk("dump_re", {63'd0, mem_readEnable}, 64'd1);
      chk("dump_cpu_rdata", cpu_readData, 64'd0);
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        chk("rst_stall", {63'd0, cpu_stall}, 64'd0);
        chk("rst_valid", {63'd0, dump_valid}, 64'd0);
        chk("rst_re", {63'd0, mem_readEnable}, 64'd0);
        chk("rst_dump_addr", dump_addr, 64'd0);
        tick();
        reset = 1'b0;
        dump  = 1'b0;
        model_reset();
        break;
      end
      if (k == bp_at) begin
        dump_ready = 1'b0;
        repeat (5) begin
          tick();
          chk("bp_addr", dump_addr, 64'(k * 8));
          chk("bp_data", dump_data, exp_mem[k]);
          chk("bp_valid", {63'd0, dump_valid}, 64'd1);
        end
        dump_ready = 1'b1;
      end
      if (k == drop_at) dump = 1'b0;
      tick();
      k++;
      cyc++;
    end
    if (cyc >= 400) chk("dump_timeout", 64'(cyc), 64'd0);
    words = k;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        exp_we;
    logic        exp_re;
    logic [63:0] exp_rdata;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int   words;

    vecs[0] = '{1'b1, 1'b0, 64'h18,  64'h0,    1'b0, 1'b1, pattern(3)};
    vecs[1] = '{1'b1, 1'b0, 64'h3F8, 64'h0,    1'b0, 1'b1, pattern(127)};
    vecs[2] = '{1'b0, 1'b1, 64'h40,  64'h1234, 1'b1, 1'b0, pattern(8)};
    vecs[3] = '{1'b0, 1'b0, 64'h8,   64'h0,    1'b0, 1'b0, pattern(1)};
    vecs[4] = '{1'b1, 1'b1, 64'h100, 64'hBEEF, 1'b1, 1'b1, pattern(32)};

    reset = 1'b1; dump = 1'b1; dump_ready = 1'b1;
    cpu_memRead = 1'b1; cpu_memWrite = 1'b1;
    cpu_addr = 64'h0; cpu_writeData = 64'h0;
    model_reset();
    repeat (2) tick();
    chk("rst_stall", {63'd0, cpu_stall}, 64'd0);
    chk("rst_valid", {63'd0, dump_valid}, 64'd0);
    chk("rst_done", {63'd0, dump_done}, 64'd0);
    chk("rst_we", {63'd0, mem_writeEnable}, 64'd0);
    chk("rst_re", {63'd0, mem_readEnable}, 64'd0);
    chk("rst_dump_addr", dump_addr, 64'd0);
    reset = 1'b0; dump = 1'b0; cpu_memRead = 1'b0; cpu_memWrite = 1'b0;
    tick();

    // IDLE passthrough table; write strobes are dropped before the next edge.
    for (int v = 0; v < 5; v++) begin
      cpu_memRead   = vecs[v].rd;
      cpu_memWrite  = vecs[v].wr;
      cpu_addr      = vecs[v].addr;
      cpu_writeData = vecs[v].wdata;
      #1;
      chk($sformatf("vec%0d_we", v), {63'd0, mem_writeEnable}, {63'd0, vecs[v].exp_we});
      chk($sformatf("vec%0d_re", v), {63'd0, mem_readEnable}, {63'd0, vecs[v].exp_re});
      chk($sformatf("vec%0d_addr", v), mem_addr, vecs[v].addr);
      chk($sformatf("vec%0d_wdata", v), mem_writeData, vecs[v].wdata);
      chk($sformatf("vec%0d_rdata", v), cpu_readData, vecs[v].exp_rdata);
      chk($sformatf("vec%0d_stall", v), {63'd0, cpu_stall}, 64'd0);
      chk($sformatf("vec%0d_valid", v), {63'd0, dump_valid}, 64'd0);
      cpu_memRead = 1'b0; cpu_memWrite = 1'b0;
      tick();
    end

    // Store then load through the passthrough path.
    cpu_memWrite = 1'b1; cpu_addr = 64'h10; cpu_writeData = 64'hA5;
    #1;
    chk("pt_we", {63'd0, mem_writeEnable}, 64'd1);
    chk("pt_addr", mem_addr, 64'h10);
    exp_mem[2] = 64'hA5;
    tick();
    cpu_memWrite = 1'b0; cpu_memRead = 1'b1;
    #1;
    chk("pt_rdata", cpu_readData, 64'hA5);
    chk("pt_stall", {63'd0, cpu_stall}, 64'd0);
    cpu_memRead = 1'b0;
    tick();

    // Dump raised alongside a store; dump drops at index 10.
    dump = 1'b1; cpu_memWrite = 1'b1; cpu_addr = 64'h20; cpu_writeData = 64'h7;
    #1;
    chk("d1_entry_we", {63'd0, mem_writeEnable}, 64'd1);
    chk("d1_entry_stall", {63'd0, cpu_stall}, 64'd0);
    exp_mem[4] = 64'h7;
    tick();
    cpu_addr = 64'h30; cpu_writeData = 64'hFF;
    run_dump(10, -1, -1, words);
    cpu_memWrite = 1'b0;
    chk("d1_words", 64'(words), 64'd128);
    chk("d1_done", {63'd0, dump_done}, 64'd1);
    chk("d1_done_stall", {63'd0, cpu_stall}, 64'd1);
    chk("d1_done_re", {63'd0, mem_readEnable}, 64'd0);
    tick();
    chk("d1_idle_done", {63'd0, dump_done}, 64'd0);
    chk("d1_idle_stall", {63'd0, cpu_stall}, 64'd0);

    // Reassert in the IDLE cycle; full dump with backpressure at index 3.
    dump = 1'b1;
    #1;
    chk("d2_idle_valid", {63'd0, dump_valid}, 64'd0);
    chk("d2_idle_stall", {63'd0, cpu_stall}, 64'd0);
    tick();
    run_dump(-1, 3, -1, words);
    chk("d2_words", 64'(words), 64'd128);
    repeat (3) begin
      chk("d2_done_hold", {63'd0, dump_done}, 64'd1);
      chk("d2_done_stall", {63'd0, cpu_stall}, 64'd1);
      tick();
    end
    dump = 1'b0;
    #1;
    chk("d2_done_last", {63'd0, dump_done}, 64'd1);
    tick();
    chk("d2_idle_done", {63'd0, dump_done}, 64'd0);
    chk("d2_idle_stall", {63'd0, cpu_stall}, 64'd0);

    // Reset in the middle of a dump at index 50.
    dump = 1'b1;
    tick();
    run_dump(-1, -1, 50, words);
    chk("d3_abort_idx", 64'(words), 64'd50);
    chk("d3_post_stall", {63'd0, cpu_stall}, 64'd0);
    chk("d3_post_valid", {63'd0, dump_valid}, 64'd0);
    chk("d3_post_done", {63'd0, dump_done}, 64'd0);

    dump = 1'b1;
    tick();
    chk("d4_first_addr", dump_addr, 64'd0);
    run_dump(0, -1, -1, words);
    chk("d4_words", 64'(words), 64'd128);
    tick();
    chk("d4_idle_stall", {63'd0, cpu_stall}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_dump_arbiter.md
DMEM_DUMP_ARBITER -- requirements
Module: dmem_dump_arbiter

Interface
REQ-001 The block SHALL take parameter N, default 64, as the data and address width in bits.
REQ-002 The block SHALL take parameter DEPTH, default 128, as the number of 64-bit data-memory words to dump.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, using the port names CLOCK_50 and reset.
REQ-004 Ports, one per line (name  direction  width  meaning):
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous active-high reset
- dump  in  1  level request to dump data memory
- cpu_memRead  in  1  MEM-stage read request
- cpu_memWrite  in  1  MEM-stage write request
- cpu_addr  in  N  MEM-stage byte address
- cpu_writeData  in  N  MEM-stage store data
- cpu_readData  out  N  load data returned to MEM stage
- cpu_stall  out  1  freezes the whole pipeline
- mem_addr  out  N  data-memory byte address
- mem_writeData  out  N  data-memory write data
- mem_writeEnable  out  1  data-memory write strobe
- mem_readEnable  out  1  data-memory read strobe
- mem_readData  in  N  data-memory read data (combinational read)
- dump_valid  out  1  dump word is presented
- dump_ready  in  1  consumer accepts the dump word
- dump_addr  out  N  byte address of the presented word
- dump_data  out  N  presented word
- dump_done  out  1  dump is complete

Function
REQ-005 The block SHALL implement an FSM with three states: IDLE, DUMP and DONE.
REQ-006 In IDLE:
- mem_* SHALL be driven from cpu_* (mem_readEnable = cpu_memRead).
- cpu_readData SHALL equal mem_readData.
- cpu_stall SHALL be 0.
- dump_valid and dump_done SHALL be 0.
REQ-007 When the FSM is in IDLE and dump = 1 is sampled at a clock edge, the FSM SHALL enter DUMP with the index cleared to 0.
- A CPU access in that same cycle completes normally.
REQ-008 In DUMP:
- cpu_stall SHALL be 1.
- mem_writeEnable SHALL be 0 and mem_readEnable SHALL be 1.
- mem_addr and dump_addr SHALL both equal index*8.
- dump_data SHALL equal mem_readData.
- dump_valid SHALL be 1.
- cpu_readData SHALL be 0.
REQ-009 The index SHALL advance by 1 only at an edge where dump_valid && dump_ready; while dump_ready = 0, the address and data SHALL hold stable.
REQ-010 A handshake on index DEPTH-1 SHALL move the FSM to DONE; the index SHALL never wrap while in DUMP.
REQ-011 The index SHALL be $clog2(DEPTH) bits wide, zero-extended and shifted left by 3 to form the byte address.
REQ-012 Deasserting dump during DUMP SHALL NOT abort the dump; it runs to completion.
REQ-013 In DONE:
- dump_done SHALL be 1, dump_valid 0, cpu_stall 1, and mem_writeEnable/mem_readEnable 0.
- The FSM SHALL return to IDLE at the first edge where dump = 0.
REQ-014 A dump reasserted in the same cycle the FSM returns to IDLE SHALL start a new dump one cycle later (IDLE is always visited for at least one cycle).
REQ-015 No CPU write SHALL reach memory in any cycle where cpu_stall = 1.

Reset
REQ-016 Reset SHALL set the FSM to IDLE and the index to 0 at the next clock edge, including when asserted mid-DUMP or in DONE.
REQ-017 While reset = 1:
- cpu_stall, dump_valid, dump_done, mem_writeEnable and mem_readEnable SHALL be 0.
- dump_addr SHALL be 0.

Structure
REQ-018 A shared package dmem_dump_pkg SHALL hold the FSM state enum (IDLE, DUMP, DONE) and the constant WORD_BYTES = 8.
REQ-019 The index register with its enable, clear and last-flag SHALL be one sub-module named dump_index_counter; the FSM and muxing SHALL stay in dmem_dump_arbiter.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Passthrough: in IDLE, cpu_memWrite=1, cpu_addr=0x10, cpu_writeData=0xA5 -> mem_writeEnable=1, mem_addr=0x10 that cycle; later read of 0x10 gives cpu_readData=0xA5, cpu_stall=0.
- Full dump with dump_ready held at 1 and DEPTH=128: dump rises -> dump_valid for exactly 128 cycles, dump_addr 0x0, 0x8, ... 0x3F8, then dump_done=1 with cpu_stall=1 throughout.
- Backpressure: dump_ready=0 for 5 cycles at index 3 -> dump_addr holds 0x18 and dump_data holds stable; the index advances on the first ready cycle.
- Dump raised together with cpu_memWrite to 0x20 of value 0x7 -> the write lands; dumped word at 0x20 equals 0x7; no write strobe during DUMP.
- Reset asserted at index 50 -> next cycle IDLE, cpu_stall=0, dump_valid=0; a new dump starts again at address 0x0.
- dump deasserted at index 10 -> the dump still completes at 0x3F8, then one DONE cycle, then IDLE.
